// File: rtl/dino_game_if.sv
// Bus between the Dino-Jump game engine and its consumers: the jump button in,
// and the sprite coordinates, death flag, score and tick strobe out.
interface dino_game_if;
  logic        jump;
  logic [11:0] dinoX;
  logic [11:0] dinoY;
  logic [11:0] obsX;
  logic [11:0] obsY;
  logic        state;
  logic [15:0] score;
  logic        tick;

  modport master (
    input  jump,
    output dinoX, dinoY, obsX, obsY, state, score, tick
  );

  modport slave (
    output jump,
    input  dinoX, dinoY, obsX, obsY, state, score, tick
  );
endinterface

// File: rtl/dino_game_engine.sv
// Dino-Jump game-state engine: jump FSM, cactus scroll, collision and score,
// all advanced once per game tick derived from the system clock.
module dino_game_engine #(
  parameter int TICK_DIV  = 833333,
  parameter int DINO_X    = 40,
  parameter int GROUND_Y  = 459,
  parameter int JUMP_H    = 90,
  parameter int JUMP_STEP = 3,
  parameter int OBS_Y     = 429,
  parameter int OBS_START = 640,
  parameter int OBS_SPEED = 4
) (
  input  logic        clk,
  input  logic        rst,
  dino_game_if.master bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [11:0] DINO_X_C  = 12'(DINO_X);
  localparam logic [11:0] GROUND_C  = 12'(GROUND_Y);
  localparam logic [11:0] APEX_C    = 12'(GROUND_Y - JUMP_H);
  localparam logic [11:0] STEP_C    = 12'(JUMP_STEP);
  localparam logic [11:0] OBS_Y_C   = 12'(OBS_Y);
  localparam logic [11:0] START_C   = 12'(OBS_START);
  localparam logic [11:0] SPEED_C   = 12'(OBS_SPEED);
  localparam logic [11:0] HIT_DINO_Y = 12'(OBS_Y + 2);
  localparam logic [11:0] HIT_OBS_X_MAX = 12'd58;
  localparam logic [11:0] OBS_REACH = 12'd13;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic             pend_q, pend_d;
  logic [1:0]       fsm_q, fsm_d;
  logic [11:0]      dino_y_q, dino_y_d;
  logic [11:0]      obs_x_q, obs_x_d;
  logic [15:0]      score_q, score_d;

  logic        tick_w;
  logic        jump_edge;
  logic        collide;
  logic        pend_clr;
  logic [11:0] rise_y;
  logic [11:0] fall_y;

  assign tick_w    = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d     = tick_w ? '0 : cnt_q + 1'b1;
  assign jump_edge = sync_q[1] & ~prev_q;
  assign rise_y    = dino_y_q - STEP_C;
  assign fall_y    = dino_y_q + STEP_C;

  // Exact overlap of the renderer's open-interval sprite boxes.
  assign collide = (obs_x_q <= HIT_OBS_X_MAX) &&
                   (obs_x_q + OBS_REACH >= DINO_X_C) &&
                   (dino_y_q >= HIT_DINO_Y);

  always_comb begin
    // NOTE: every output gets a hold default first so no path infers a latch.
    fsm_d    = fsm_q;
    dino_y_d = dino_y_q;
    obs_x_d  = obs_x_q;
    score_d  = score_q;
    pend_clr = 1'b0;

    if (tick_w) begin
      if (fsm_q != S_DEAD && collide) begin
        fsm_d    = S_DEAD;
        pend_clr = 1'b1;
      end else if (fsm_q == S_DEAD) begin
        if (pend_q) begin
          fsm_d    = S_RUN;
          dino_y_d = GROUND_C;
          obs_x_d  = START_C;
          score_d  = '0;
          pend_clr = 1'b1;
        end
      end else begin
        score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
        obs_x_d = (obs_x_q < SPEED_C) ? START_C : obs_x_q - SPEED_C;
        case (fsm_q)
          S_RUN: begin
            if (pend_q) begin
              pend_clr = 1'b1;
              fsm_d    = S_RISE;
              dino_y_d = rise_y;
            end
          end
          S_RISE: begin
            dino_y_d = rise_y;
            if (rise_y <= APEX_C) fsm_d = S_FALL;
          end
          S_FALL: begin
            if (fall_y >= GROUND_C) begin
              dino_y_d = GROUND_C;
              fsm_d    = S_RUN;
            end else begin
              dino_y_d = fall_y;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A fresh edge wins over a same-cycle consume, so it fires on the next tick.
  assign pend_d = jump_edge | (pend_q & ~pend_clr);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pend_q   <= 1'b0;
      fsm_q    <= S_RUN;
      dino_y_q <= GROUND_C;
      obs_x_q  <= START_C;
      score_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= {sync_q[0], bus.jump};
      prev_q   <= sync_q[1];
      pend_q   <= pend_d;
      fsm_q    <= fsm_d;
      dino_y_q <= dino_y_d;
      obs_x_q  <= obs_x_d;
      score_q  <= score_d;
    end
  end

  assign bus.dinoX = DINO_X_C;
  assign bus.dinoY = dino_y_q;
  assign bus.obsX  = obs_x_q;
  assign bus.obsY  = OBS_Y_C;
  assign bus.state = (fsm_q == S_DEAD);
  assign bus.score = score_q;
  assign bus.tick  = tick_w;

endmodule

// File: tb/tb_dino_game_engine.sv
// Scoreboard bench for dino_game_engine at TICK_DIV=4: the stimulus queues
// hand-derived per-tick expectations, a monitor checks them after each tick.
module tb_dino_game_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dino_game_if bus ();

  dino_game_engine #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int n;
    int y;
    int x;
    int st;
    int sc;
  } exp_t;

  exp_t sb_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   tick_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int n, input int y, input int x,
                               input int st, input int sc);
    exp_t e;
    e.n = n; e.y = y; e.x = x; e.st = st; e.sc = sc;
    sb_q.push_back(e);
  endfunction

  // Dino height k ticks after a jump starts (k<=0 or k>60: grounded).
  function automatic int jy(input int k);
    if (k <= 0 || k > 60) return 459;
    if (k <= 30) return 459 - 3 * k;
    return 369 + 3 * (k - 30);
  endfunction

  // Monitor: counts ticks since reset, compares the state visible after each.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        tick_cnt = 0;
      end else if (bus.tick) begin
        @(posedge clk);
        #1;
        if (!rst) begin
          tick_cnt++;
          while (sb_q.size() > 0 && sb_q[0].n <= tick_cnt) begin
            e = sb_q.pop_front();
            if (e.n < tick_cnt) begin
              check($sformatf("t%0d missed", e.n), tick_cnt, e.n);
            end else begin
              check($sformatf("t%0d dinoX", e.n), bus.dinoX, 40);
              check($sformatf("t%0d dinoY", e.n), bus.dinoY, e.y);
              check($sformatf("t%0d obsX", e.n), bus.obsX, e.x);
              check($sformatf("t%0d obsY", e.n), bus.obsY, 429);
              check($sformatf("t%0d state", e.n), bus.state, e.st);
              check($sformatf("t%0d score", e.n), bus.score, e.sc);
            end
          end
        end
      end
    end
  end

  task automatic wait_tick(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (tick_cnt >= n) return;
      @(posedge clk);
      #2;
    end
    check($sformatf("wait for tick %0d", n), tick_cnt, n);
  endtask

  task automatic press(input int cycles);
    bus.jump = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    bus.jump = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dinoX"}, bus.dinoX, 40);
    check({tag, " dinoY"}, bus.dinoY, 459);
    check({tag, " obsX"}, bus.obsX, 640);
    check({tag, " obsY"}, bus.obsY, 429);
    check({tag, " state"}, bus.state, 0);
    check({tag, " score"}, bus.score, 0);
    check({tag, " tick"}, bus.tick, 0);
  endtask

  initial begin
    bus.jump = 1'b0;

    // Reset values and tick cadence.
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("tick cycle %0d", c), bus.tick, (c % 4 == 3) ? 1 : 0);
    end

    // Asynchronous reset in mid-count after the cactus has moved.
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle run into the cactus, then frozen in DEAD.
    push(1, 459, 636, 0, 1);
    push(146, 459, 56, 0, 146);
    for (int n = 147; n <= 167; n++) push(n, 459, 56, 1, 146);
    wait_tick(167);

    // Restart from DEAD with a short press.
    push(168, 459, 640, 0, 0);
    push(169, 459, 636, 0, 1);
    press(3);
    wait_tick(169);

    // Fresh game: jump held from release, then cactus clearing, then buffered jump.
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.jump = 1'b1;
    for (int n = 1; n <= 62; n++) push(n, jy(n), 640 - 4 * n, 0, n);
    for (int n = 131; n <= 161; n++)
      push(n, jy(n - 130), (n <= 160) ? 640 - 4 * n : 640, 0, n);
    push(170, jy(40), 640 - 4 * 9, 0, 170);
    push(189, jy(59), 640 - 4 * 28, 0, 189);
    push(190, 459, 640 - 4 * 29, 0, 190);
    push(191, 456, 640 - 4 * 30, 0, 191);
    push(205, jy(15), 640 - 4 * 44, 0, 205);
    push(220, 369, 640 - 4 * 59, 0, 220);
    push(221, 372, 640 - 4 * 60, 0, 221);
    push(250, 459, 640 - 4 * 89, 0, 250);
    push(251, 459, 640 - 4 * 90, 0, 251);
    push(252, 459, 640 - 4 * 91, 0, 252);

    repeat (100) @(posedge clk);
    #2;
    bus.jump = 1'b0;

    wait_tick(130);
    press(8);
    wait_tick(170);
    press(3);
    wait_tick(180);
    press(3);
    wait_tick(252);

    check("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
